// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared limits, stage names and counter width for the pipeline latch controller.
package pipe_ctrl_pkg;

    // Upper bounds on the controller's parameters
    localparam int PIPE_STAGE_MAX = 16;
    localparam int PIPE_MC_MAX    = 8;

    // Latch indices of the classic five-stage in-order core
    localparam int STG_IF_ID   = 0;
    localparam int STG_ID_EXE  = 1;
    localparam int STG_EXE_MEM = 2;
    localparam int STG_MEM_WB  = 3;

    // Width of the optional performance counters
    localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/mc_busy_tracker.sv
// mc_busy_tracker: busy flag for one multi-cycle unit, set by a start pulse and cleared by a done pulse.
module mc_busy_tracker (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic done,
    output logic busy
);

    // An idle unit only listens to start (a same-cycle done is ignored); a busy unit only listens to done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
        end else if (busy) begin
            busy <= ~done;
        end else begin
            busy <= start;
        end
    end

endmodule

// File: rtl/pipeline_ctrl_n.sv
// pipeline_ctrl_n: load enables, flushes and valid bits for NUM_STAGES pipeline latches.
// Combines post-reset warm-up, stall hold propagation, flush squashing and a whole-pipe
// freeze while any multi-cycle unit is busy.
// Optional freeze/stall cycle counters are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl_n
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES   = 4,
    parameter int NUM_MC_UNITS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_STAGES-1:0]   i_stall_req,
    input  logic [NUM_STAGES-1:0]   i_flush_req,
    input  logic [NUM_MC_UNITS-1:0] i_mc_start,
    input  logic [NUM_MC_UNITS-1:0] i_mc_done,
    output logic [NUM_STAGES-1:0]   o_stage_ena,
    output logic [NUM_STAGES-1:0]   o_stage_flush,
    output logic [NUM_STAGES-1:0]   o_stage_valid,
    output logic [NUM_MC_UNITS-1:0] o_mc_busy,
    output logic                    o_freeze,
    output logic [PERF_CNT_W-1:0]   o_perf_freeze_cnt,
    output logic [PERF_CNT_W-1:0]   o_perf_stall_cnt
);

    logic [NUM_STAGES-1:0]   fill_q;
    logic [NUM_STAGES-1:0]   valid_q;
    logic [NUM_STAGES-1:0]   hold;
    logic [NUM_STAGES-1:0]   flush_hit;
    logic [NUM_STAGES-1:0]   bubble;
    logic [NUM_STAGES-1:0]   stage_ena;
    logic [NUM_STAGES-1:0]   load_val;
    logic [NUM_MC_UNITS-1:0] busy_q;
    logic                    freeze;

    genvar u;
    generate
        for (u = 0; u < NUM_MC_UNITS; u++) begin : g_mc
            mc_busy_tracker u_tracker (
                .clk   (clk),
                .reset (reset),
                .start (i_mc_start[u]),
                .done  (i_mc_done[u]),
                .busy  (busy_q[u])
            );
        end
    endgenerate

    assign freeze = |busy_q;

    // Stall and flush requests reach every upstream latch; a bubble enters where a hold boundary lies
    always_comb begin
        hold      = '0;
        flush_hit = '0;
        bubble    = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            hold[i]      = |(i_stall_req >> i);
            flush_hit[i] = |(i_flush_req >> i);
        end
        for (int i = 1; i < NUM_STAGES; i++) begin
            bubble[i] = hold[i-1] & ~hold[i];
        end
    end

    assign stage_ena = fill_q & ~{NUM_STAGES{freeze}} & ~hold & ~flush_hit;
    assign load_val  = {valid_q[NUM_STAGES-2:0], 1'b1} & ~bubble;

    // Warm-up shift register: one more latch becomes live each unfrozen cycle after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_q <= '0;
        end else if (!freeze) begin
            fill_q <= {fill_q[NUM_STAGES-2:0], 1'b1};
        end
    end

    // Valid bits follow the data: squashed latches clear, enabled latches load from upstream
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= (valid_q & ~flush_hit & ~stage_ena) | (load_val & stage_ena);
        end
    end

    assign o_stage_ena   = stage_ena;
    assign o_stage_flush = flush_hit & fill_q;
    assign o_stage_valid = valid_q;
    assign o_mc_busy     = busy_q;
    assign o_freeze      = freeze;

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_CNT_W-1:0] freeze_cnt_q;
    logic [PERF_CNT_W-1:0] stall_cnt_q;

    // Saturating counts of frozen cycles and of unfrozen cycles carrying any stall request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            freeze_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (freeze && (freeze_cnt_q != '1)) begin
                freeze_cnt_q <= freeze_cnt_q + 1'b1;
            end
            if (!freeze && (|i_stall_req) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign o_perf_freeze_cnt = freeze_cnt_q;
    assign o_perf_stall_cnt  = stall_cnt_q;
`else
    assign o_perf_freeze_cnt = '0;
    assign o_perf_stall_cnt  = '0;
`endif

endmodule

// File: doc/pipeline_ctrl_n.md
Name: pipeline_ctrl_n

Overview:
- Parametrised pipeline-latch controller for the in-order core.
- Drives per-latch enables and flushes for NUM_STAGES inter-stage registers: index 0 = IF/ID, index NUM_STAGES-1 = last latch before writeback.
- Combines a post-reset warm-up fill, per-stage stall requests with upstream hold propagation, and per-stage flush requests.
- Tracks NUM_MC_UNITS multi-cycle units (divider, multiplier, ...); any busy unit freezes the whole pipe.
- Also tracks a valid bit per latch so downstream logic can distinguish bubbles.

Parameters:
- NUM_STAGES, 4, number of pipeline latches controlled (2..16).
- NUM_MC_UNITS, 2, number of multi-cycle units with start/done handshake (1..8).

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- i_stall_req  in  NUM_STAGES  bit k: stage feeding latch k+1 cannot advance (data hazard, exception answer).
- i_flush_req  in  NUM_STAGES  bit k: squash contents of latches 0..k.
- i_mc_start  in  NUM_MC_UNITS  one-cycle start pulse per unit.
- i_mc_done  in  NUM_MC_UNITS  one-cycle completion pulse per unit.
- o_stage_ena  out  NUM_STAGES  latch load enable.
- o_stage_flush  out  NUM_STAGES  latch synchronous clear (load bubble).
- o_stage_valid  out  NUM_STAGES  latch holds a real instruction.
- o_mc_busy  out  NUM_MC_UNITS  registered busy flag per unit.
- o_freeze  out  1  OR of o_mc_busy.
- o_perf_freeze_cnt  out  32  freeze-cycle counter (optional feature).
- o_perf_stall_cnt  out  32  stall-cycle counter (optional feature).

Behaviour:
- Reset (async, any time, including mid-divide): fill_q=0, valid_q=0, mc busy=0, counters=0. While reset is high, o_stage_ena=0 and o_stage_flush=0.
- Warm-up: when not frozen, fill_q <= {fill_q[NUM_STAGES-2:0],1'b1}. fill_q[i] first high i+1 cycles after reset deasserts. Fill holds during freeze.
- Busy tracking per unit u, registered:
  - busy & done -> 0.
  - ~busy & start -> 1.
  - start while busy is ignored.
  - done while idle is ignored.
  - start & done together while idle -> 1 (done is ignored).
- Freeze: freeze = |busy_q. A unit's start cycle itself is not frozen; freeze begins the next cycle.
- Hold: hold[i] = |i_stall_req[NUM_STAGES-1:i]. A stall at k holds latches 0..k.
- Enable: o_stage_ena[i] = fill_q[i] & ~freeze & ~hold[i] & ~flush_hit[i].
- Bubble insertion: for i>0, if hold[i-1] & ~hold[i], latch i loads a bubble (valid_q[i] <= 0) while latches 0..i-1 hold.
- Flush: flush_hit[i] = |i_flush_req[NUM_STAGES-1:i].
  - o_stage_flush[i] = flush_hit[i] & fill_q[i].
  - Flush overrides stall and freeze for the squashed latches; valid_q[i] <= 0 next cycle.
  - Downstream latches obey the normal rules.
- Valid update on o_stage_ena[i]: valid_q[i] <= (i==0) ? 1 : (valid_q[i-1] & ~bubble[i]). Otherwise valid_q holds unless flushed.
- o_stage_valid = valid_q.
- Priority per latch: reset > flush > freeze > stall > advance.
- Outputs o_stage_ena and o_stage_flush are combinational from registered state plus stall/flush inputs. No latency from i_stall_req to o_stage_ena.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined:
  - o_perf_freeze_cnt increments every cycle freeze=1.
  - o_perf_stall_cnt increments every cycle with ~freeze & |i_stall_req.
  - Both saturate at 32'hFFFFFFFF and are cleared by reset.
- Undefined: both ports tied to 0, and no counter flops are built.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - PIPE_STAGE_MAX=16 and PIPE_MC_MAX=8 limits.
  - Named stage-index constants STG_IF_ID=0, STG_ID_EXE=1, STG_EXE_MEM=2, STG_MEM_WB=3.
  - PERF_CNT_W=32.
- One sub-module, mc_busy_tracker (single-unit start/done busy flop), instantiated NUM_MC_UNITS times via generate.

Test Plan:
- Warm-up: release reset, no stalls -> o_stage_ena goes 0001, 0011, 0111, 1111 on cycles 1..4. o_stage_valid fills one cycle behind each enable.
- Stall: i_stall_req=4'b0010 for 2 cycles after warm-up -> o_stage_ena=4'b1100 both cycles. valid_q[2] becomes 0 (bubble); latches 0,1 keep their valid=1.
- Divider: pulse i_mc_start[0], i_mc_done[0] 10 cycles later -> o_mc_busy[0]=1 and o_stage_ena=0 for exactly 10 cycles, then enables resume at 1111. A second i_mc_start[0] mid-busy has no effect.
- Flush vs stall: i_flush_req=4'b0100 with i_stall_req=4'b1000 in the same cycle -> o_stage_flush=4'b0111, o_stage_ena=4'b0000. Next cycle valid_q[2:0]=000, valid_q[3] unchanged.
- Async reset asserted mid-freeze (busy_q=01) between clock edges -> o_mc_busy=0, o_stage_ena=0, o_stage_valid=0 immediately. After deassert, warm-up repeats from 0001.
- With PIPE_CTRL_PERF_EN: a 10-cycle divide plus 2 stall cycles -> o_perf_freeze_cnt=10, o_perf_stall_cnt=2. Without the macro, both read 0.
